// File: rtl/pu_wr_arbiter_pkg.sv
// Shared types and helpers for the PU write-back arbiter.
// No logic; constant width helper plus FSM state encoding.
// No flow control of its own.
package pu_wr_arbiter_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_LOCK = 1'b1
    } arb_state_t;

    // Ceiling log2, never below 1, so single-entry fields still get a bit.
    function automatic int c_log_2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/pu_wr_arbiter_rr_pick.sv
// Round-robin picker: first requester strictly above 'last', wrapping around.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to sample the pick.
module rr_pick
    import pu_wr_arbiter_pkg::*;
#(
    parameter int NUM_PU  = 4,
    parameter int PU_ID_W = c_log_2(NUM_PU)
) (
    input  logic [NUM_PU-1:0]  req,
    input  logic [PU_ID_W-1:0] last,
    output logic [PU_ID_W-1:0] grant_id,
    output logic               found
);

    int idx;

    // Walk offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        grant_id = '0;
        found    = 1'b0;
        idx      = 0;
        for (int k = NUM_PU; k >= 1; k--) begin
            idx = (int'(last) + k) % NUM_PU;
            if (req[idx]) begin
                grant_id = PU_ID_W'(idx);
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pu_wr_arbiter.sv
// Round-robin burst arbiter from NUM_PU write streams to one memory write port; optional PU_WR_ARB_STATS_EN counters.
// Latency: request to first accept 2 cycles, accept to mem_write_valid 1 cycle; one idle cycle between bursts.
// Backpressure: pu_write_ready of the granted PU follows the single output stage (free or draining this cycle).
module pu_wr_arbiter
    import pu_wr_arbiter_pkg::*;
#(
    parameter int NUM_PU     = 4,
    parameter int DATA_W     = 64,
    parameter int BURST_LEN  = 16,
    parameter int PU_ID_W    = c_log_2(NUM_PU),
    parameter int BEAT_CNT_W = c_log_2(BURST_LEN) + 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_PU-1:0]        pu_write_req,
    input  logic [NUM_PU-1:0]        pu_write_last,
    input  logic [NUM_PU*DATA_W-1:0] pu_write_data,
    output logic [NUM_PU-1:0]        pu_write_ready,
    output logic                     mem_write_valid,
    output logic [DATA_W-1:0]        mem_write_data,
    output logic [PU_ID_W-1:0]       mem_write_id,
    output logic                     mem_write_last,
    input  logic                     mem_write_ready,
    output logic                     busy
`ifdef PU_WR_ARB_STATS_EN
    ,
    output logic [31:0]              beats_total,
    output logic [NUM_PU*16-1:0]     grants_per_pu
`endif
);

    localparam logic [BEAT_CNT_W-1:0] CNT_MAX    = BEAT_CNT_W'(BURST_LEN - 1);
    localparam logic [BEAT_CNT_W-1:0] CNT_ONE    = BEAT_CNT_W'(1);
    localparam logic [PU_ID_W-1:0]    RESET_LAST = PU_ID_W'(NUM_PU - 1);

    arb_state_t          state;
    logic [PU_ID_W-1:0]  grant;
    logic [PU_ID_W-1:0]  last_grant;
    logic [BEAT_CNT_W-1:0] beat_cnt;
    logic [PU_ID_W-1:0]  pick_id;
    logic                pick_found;
    logic                stage_free;
    logic                accept;
    logic                burst_end;

    rr_pick #(
        .NUM_PU  (NUM_PU),
        .PU_ID_W (PU_ID_W)
    ) u_rr_pick (
        .req      (pu_write_req),
        .last     (last_grant),
        .grant_id (pick_id),
        .found    (pick_found)
    );

    // The stage can take a new beat if empty or if its current beat leaves this cycle.
    assign stage_free = !mem_write_valid || mem_write_ready;
    assign accept     = (state == ARB_LOCK) && pu_write_req[grant] && stage_free;
    assign burst_end  = accept && (pu_write_last[grant] || (beat_cnt == CNT_MAX));
    assign busy       = (state == ARB_LOCK) || mem_write_valid;

    always_comb begin
        pu_write_ready = '0;
        if (state == ARB_LOCK) begin
            pu_write_ready[grant] = stage_free;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ARB_IDLE;
            grant      <= '0;
            last_grant <= RESET_LAST;
            beat_cnt   <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (pick_found) begin
                        grant    <= pick_id;
                        beat_cnt <= '0;
                        state    <= ARB_LOCK;
                    end
                end
                ARB_LOCK: begin
                    if (accept) begin
                        beat_cnt <= beat_cnt + CNT_ONE;
                        if (burst_end) begin
                            last_grant <= grant;
                            state      <= ARB_IDLE;
                        end
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_write_valid <= 1'b0;
            mem_write_data  <= '0;
            mem_write_id    <= '0;
            mem_write_last  <= 1'b0;
        end else if (accept) begin
            mem_write_valid <= 1'b1;
            mem_write_data  <= pu_write_data[int'(grant)*DATA_W +: DATA_W];
            mem_write_id    <= grant;
            mem_write_last  <= burst_end;
        end else if (mem_write_ready) begin
            mem_write_valid <= 1'b0;
        end
    end

`ifdef PU_WR_ARB_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            beats_total <= '0;
        end else if (accept && (beats_total != 32'hffff_ffff)) begin
            beats_total <= beats_total + 32'd1;
        end
    end

    for (genvar i = 0; i < NUM_PU; i++) begin : g_grant_cnt
        logic [15:0] cnt;
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                cnt <= '0;
            end else if ((state == ARB_IDLE) && pick_found && (pick_id == PU_ID_W'(i))
                         && (cnt != 16'hffff)) begin
                cnt <= cnt + 16'd1;
            end
        end
        assign grants_per_pu[i*16 +: 16] = cnt;
    end
`endif

endmodule

// File: tb/tb_pu_wr_arbiter.sv
// Bench for pu_wr_arbiter: directed bursts, random traffic, mid-burst reset, all against a beat-level model.
module tb_pu_wr_arbiter;

    localparam int NUM_PU    = 4;
    localparam int DATA_W    = 64;
    localparam int BURST_LEN = 16;
    localparam int PU_ID_W   = 2;

    logic                     clk;
    logic                     reset;
    logic [NUM_PU-1:0]        pu_write_req;
    logic [NUM_PU-1:0]        pu_write_last;
    logic [NUM_PU*DATA_W-1:0] pu_write_data;
    logic [NUM_PU-1:0]        pu_write_ready;
    logic                     mem_write_valid;
    logic [DATA_W-1:0]        mem_write_data;
    logic [PU_ID_W-1:0]       mem_write_id;
    logic                     mem_write_last;
    logic                     mem_write_ready;
    logic                     busy;

    pu_wr_arbiter #(
        .NUM_PU    (NUM_PU),
        .DATA_W    (DATA_W),
        .BURST_LEN (BURST_LEN)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .pu_write_req    (pu_write_req),
        .pu_write_last   (pu_write_last),
        .pu_write_data   (pu_write_data),
        .pu_write_ready  (pu_write_ready),
        .mem_write_valid (mem_write_valid),
        .mem_write_data  (mem_write_data),
        .mem_write_id    (mem_write_id),
        .mem_write_last  (mem_write_last),
        .mem_write_ready (mem_write_ready),
        .busy            (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Source side: each PU streams numbered beats in bursts of 'rem' beats.
    int rem     [NUM_PU];
    int src_seq [NUM_PU];
    int out_seq [NUM_PU];
    bit src_en  [NUM_PU];
    bit nolast;
    int drop_pct, rdy_pct, newburst_pct;

    // Reference model: grant owner, beats in current grant, one-deep output slot.
    typedef struct {
        logic [63:0] d;
        int          id;
        bit          last;
    } beat_t;
    bit    m_granted;
    int    m_g;
    int    m_last_grant;
    int    m_cnt;
    beat_t m_pend[$];

    function automatic logic [63:0] mkdata(input int p, input int s);
        return {p[31:0], s[31:0]};
    endfunction

    task automatic model_reset();
        m_granted    = 1'b0;
        m_g          = 0;
        m_last_grant = NUM_PU - 1;
        m_cnt        = 0;
        m_pend.delete();
    endtask

    task automatic drive_inputs();
        for (int p = 0; p < NUM_PU; p++) begin
            if (rem[p] == 0 && src_en[p] && $urandom_range(0, 99) < newburst_pct)
                rem[p] = $urandom_range(1, 20);
            pu_write_req[p]  = (rem[p] > 0) && ($urandom_range(0, 99) >= drop_pct);
            pu_write_last[p] = !nolast && (rem[p] == 1);
            pu_write_data[p*DATA_W +: DATA_W] = mkdata(p, src_seq[p]);
        end
        mem_write_ready = ($urandom_range(0, 99) < rdy_pct);
    endtask

    task automatic check_outputs();
        logic [NUM_PU-1:0] exp_rdy;
        int p;
        exp_rdy = '0;
        if (m_granted && (m_pend.size() == 0 || mem_write_ready)) exp_rdy[m_g] = 1'b1;
        chk("ready", 64'(pu_write_ready), 64'(exp_rdy));
        chk("valid", 64'(mem_write_valid), 64'(m_pend.size() != 0));
        chk("busy", 64'(busy), 64'(m_granted || m_pend.size() != 0));
        if (m_pend.size() != 0) begin
            chk("data", mem_write_data, m_pend[0].d);
            chk("id", 64'(mem_write_id), 64'(m_pend[0].id));
            chk("last", 64'(mem_write_last), 64'(m_pend[0].last));
        end
        if (mem_write_valid && mem_write_ready) begin
            p = int'(mem_write_id);
            chk("stream", mem_write_data, mkdata(p, out_seq[p]));
            out_seq[p]++;
        end
    endtask

    task automatic advance_sources();
        for (int p = 0; p < NUM_PU; p++) begin
            if (pu_write_req[p] && pu_write_ready[p]) begin
                src_seq[p]++;
                rem[p]--;
            end
        end
    endtask

    // What the next rising edge should do, stated as burst-level rules.
    task automatic model_step();
        beat_t b;
        bit    acc;
        bit    was_granted;
        acc = m_granted && pu_write_req[m_g] && (m_pend.size() == 0 || mem_write_ready);
        if (m_pend.size() != 0 && mem_write_ready) void'(m_pend.pop_front());
        was_granted = m_granted;
        if (acc) begin
            b.d    = pu_write_data[m_g*DATA_W +: DATA_W];
            b.id   = m_g;
            b.last = pu_write_last[m_g] || (m_cnt == BURST_LEN - 1);
            m_pend.push_back(b);
            m_cnt++;
            if (b.last) begin
                m_granted    = 1'b0;
                m_last_grant = m_g;
            end
        end
        if (!was_granted) begin
            for (int k = 1; k <= NUM_PU; k++) begin
                int idx;
                idx = (m_last_grant + k) % NUM_PU;
                if (!m_granted && pu_write_req[idx]) begin
                    m_granted = 1'b1;
                    m_g       = idx;
                    m_cnt     = 0;
                end
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        drive_inputs();
        #1;
        check_outputs();
        advance_sources();
        model_step();
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_ready"}, 64'(pu_write_ready), 64'(0));
        chk({tag, "_valid"}, 64'(mem_write_valid), 64'(0));
        chk({tag, "_data"}, mem_write_data, 64'(0));
        chk({tag, "_id"}, 64'(mem_write_id), 64'(0));
        chk({tag, "_last"}, 64'(mem_write_last), 64'(0));
        chk({tag, "_busy"}, 64'(busy), 64'(0));
    endtask

    task automatic apply_reset(input string tag);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_reset_values(tag);
        model_reset();
        for (int p = 0; p < NUM_PU; p++) begin
            rem[p]     = 0;
            out_seq[p] = src_seq[p];
        end
        pu_write_req = '0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic set_all_en(input bit en);
        for (int p = 0; p < NUM_PU; p++) src_en[p] = en;
    endtask

    initial begin
        bit done;
        bit seen;
        pu_write_req    = '0;
        pu_write_last   = '0;
        pu_write_data   = '0;
        mem_write_ready = 1'b0;
        nolast          = 1'b0;
        drop_pct        = 0;
        rdy_pct         = 100;
        newburst_pct    = 0;
        for (int p = 0; p < NUM_PU; p++) begin
            rem[p] = 0; src_seq[p] = 0; out_seq[p] = 0; src_en[p] = 1'b0;
        end
        model_reset();
        reset = 1'b1;
        #1;
        reset = 1'b0;
        #1;
        check_reset_values("por");
        @(negedge clk);
        reset = 1'b1;

        // Single 4-beat burst from PU2 with an open output.
        rem[2] = 4;
        repeat (12) cycle();

        // PU0 and PU3 streaming without last: bursts capped and alternating.
        nolast = 1'b1;
        rem[0] = 1000;
        rem[3] = 1000;
        repeat (90) cycle();
        nolast = 1'b0;
        rem[0] = 2;
        rem[3] = 2;
        repeat (12) cycle();

        // All PUs requesting from a fresh reset: order starts at PU0.
        apply_reset("rst1");
        for (int p = 0; p < NUM_PU; p++) rem[p] = 3;
        repeat (25) cycle();

        // Random traffic with output backpressure and request dropouts.
        set_all_en(1'b1);
        drop_pct     = 15;
        rdy_pct      = 65;
        newburst_pct = 30;
        repeat (1500) cycle();

        // Reset while a beat sits in the output stage and a grant is open.
        done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            cycle();
            if (m_granted && m_pend.size() != 0) done = 1'b1;
        end
        chk("midburst_found", 64'(done), 64'(1));
        set_all_en(1'b0);
        drop_pct = 0;
        rdy_pct  = 100;
        apply_reset("rst2");
        for (int p = 0; p < NUM_PU; p++) rem[p] = 2;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            cycle();
            if (mem_write_valid) begin
                seen = 1'b1;
                chk("post_reset_id", 64'(mem_write_id), 64'(0));
            end
        end
        chk("post_reset_seen", 64'(seen), 64'(1));

        // Drain everything and confirm no beat was lost or duplicated.
        done = 1'b0;
        for (int i = 0; i < 2000 && !done; i++) begin
            cycle();
            done = (rem[0] == 0) && (rem[1] == 0) && (rem[2] == 0) && (rem[3] == 0)
                   && !m_granted && (m_pend.size() == 0);
        end
        chk("drain_done", 64'(done), 64'(1));
        for (int p = 0; p < NUM_PU; p++) chk("delivered", 64'(out_seq[p]), 64'(src_seq[p]));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pu_wr_arbiter.md
# pu_wr_arbiter

Round-robin write-back arbiter between `NUM_PU` processing units and the single memory-controller write port. Each PU's `write_req`/`write_data` stream (PE or pooling output) is granted in bursts. Accepted beats are forwarded through one registered output stage tagged with the source PU ID and a last-beat flag. It sits between the PU array and the write side of the memory controller.

## Interface
Parameters:
- `NUM_PU`, 4, number of requesting PUs (2..16)
- `DATA_W`, 64, write data width per PU (OP_WIDTH*NUM_PE)
- `BURST_LEN`, 16, maximum beats per grant (≥1)
- `PU_ID_W`, `C_LOG_2(NUM_PU)`, source ID width
- `BEAT_CNT_W`, `C_LOG_2(BURST_LEN)+1`, beat counter width

Ports:
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low reset; asserts immediately, deasserts synchronously to `clk`
- `pu_write_req`  in  NUM_PU  per-PU beat valid
- `pu_write_last`  in  NUM_PU  per-PU end-of-burst marker, qualified by `pu_write_req`
- `pu_write_data`  in  NUM_PU*DATA_W  packed per-PU data; PU i occupies `[i*DATA_W +: DATA_W]`
- `pu_write_ready`  out  NUM_PU  per-PU accept; one-hot or zero
- `mem_write_valid`  out  1  output beat valid
- `mem_write_data`  out  DATA_W  output beat data
- `mem_write_id`  out  PU_ID_W  source PU of the beat
- `mem_write_last`  out  1  final beat of the granted burst
- `mem_write_ready`  in  1  memory controller accept
- `busy`  out  1  high in LOCK or while `mem_write_valid` is high

## Operation
- FSM states:
  - IDLE: no grant. When any `pu_write_req` is high, select a PU round-robin, starting the search at `last_grant+1` mod NUM_PU and moving upward. Load `grant` and clear `beat_cnt`. Go to LOCK in the next cycle.
  - LOCK: `pu_write_ready[grant] = stage_free`, where `stage_free = !mem_write_valid || mem_write_ready`. A beat is accepted when `pu_write_req[grant] && pu_write_ready[grant]`. Each accepted beat increments `beat_cnt`.
  - Burst ends on the accepted beat that has `pu_write_last` high, or on the accepted beat where `beat_cnt == BURST_LEN-1`. That beat is loaded with `mem_write_last=1`. Update `last_grant=grant` and return to IDLE.
- While in LOCK, a deasserted `pu_write_req[grant]` stalls: the grant is held and no other PU is served. PUs must finish bursts with `pu_write_last`.
- Output stage: on accept, load data, `grant` as ID, and the last flag. `mem_write_valid` holds with stable payload until `mem_write_ready`.
- Non-granted PUs see `pu_write_ready=0` and are never dropped.
- Reset mid-burst: all state is cleared and any buffered beat is discarded. The PU must restart the burst.

## Timing
- Reset values: `pu_write_ready=0`, `mem_write_valid=0`, `mem_write_data=0`, `mem_write_id=0`, `mem_write_last=0`, `busy=0`, state IDLE, `last_grant=NUM_PU-1` (so PU0 wins first).
- Request to first accept: 2 cycles (IDLE select, then LOCK ready). Accept to `mem_write_valid`: 1 cycle.
- Sustained throughput: 1 beat/cycle while `mem_write_ready=1`. There is one idle bubble between bursts.
- `pu_write_ready` combinationally depends on `mem_write_ready`. There is no other combinational path from input to output.

## Configuration
- `PU_WR_ARB_STATS_EN` defined: adds output `beats_total` (32 bits) and output `grants_per_pu` (NUM_PU*16 bits, packed like data).
  - `beats_total` counts accepted beats.
  - `grants_per_pu` counts IDLE→LOCK transitions per PU.
  - All counters saturate and reset to 0.
- Without the macro: those ports and counters do not exist. Behaviour is otherwise identical.

## Structure
- Shared package/header (`common.vh`): `C_LOG_2`, FSM state encodings `ARB_IDLE=1'b0` and `ARB_LOCK=1'b1`.
- One sub-module, `rr_pick`: combinational round-robin priority picker with inputs `req[NUM_PU]` and `last[PU_ID_W]`, outputs `grant_id` and `found`. Instantiated once. Everything else stays in the top.

## Test plan
- Single PU2 burst of 4 beats with `last` on beat 4, `mem_write_ready=1`:
  - `mem_write_id=2`, data in order.
  - `mem_write_last` only on beat 4.
  - FSM back to IDLE.
- PU0 and PU3 requesting continuously, BURST_LEN=16, no `last`:
  - 16-beat bursts alternate 0,3,0,3.
  - `mem_write_last` on every 16th beat.
  - One bubble between bursts.
- All 4 PUs requesting from reset: grant order 0,1,2,3,0.
- `mem_write_ready` toggled 1,0,0,1 mid-burst:
  - Payload stable while stalled.
  - `pu_write_ready` low in the stalled cycles.
  - No beat lost or duplicated.
- PU1 drops `req` for 3 cycles mid-burst while PU2 requests: grant stays on PU1, and PU2 is served only after PU1's last beat.
- `reset` asserted low mid-burst with `mem_write_valid=1`: outputs are at reset values in the same cycle, and the next grant goes to PU0.
